pla_b11_capture: RTL and testbench

Registered capture stage directly downstream of the b11 PLA decode. It samples the 31-bit z vector when the upstream qualifier is high and discards words equal to the last accepted one when de-duplication is enabled. Accepted words are buffered in a small FIFO and presented to the consumer over a valid/ready interface. Words that arrive while the FIFO is full are dropped and counted.

---
 rtl/pla_b11_capture.sv | 114 +++++++++++
 tb/tb_pla_b11_capture.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pla_b11_capture.sv
`default_nettype none
//==== pla_b11_capture : de-duplicating capture FIFO behind the b11 PLA decode ====
// Rev 1.0 - initial release
module pla_b11_capture #(
  parameter int DEPTH = 4,
  parameter int W     = 31,
  parameter bit DEDUP = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [W-1:0]             in_z,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_z,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  input  logic                     drop_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]    C_FULL    = LW'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [W-1:0]     r_last;
  logic             r_last_vld;
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_nonempty;
  logic w_cand;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_nonempty = (r_level != '0);

  // A duplicate of the last accepted word is not even a candidate, so it
  // can never be counted as a drop or refresh the last-word register.
  assign w_cand = in_valid & (!DEDUP | ~r_last_vld | (in_z != r_last));
  assign w_pop  = w_nonempty & out_ready;
  assign w_push = w_cand & ((r_level != C_FULL) | w_pop);
  assign w_drop = w_cand & ~w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wptr] <= in_z;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
    end else if (w_push) begin
      r_last     <= in_z;
      r_last_vld <= 1'b1;
    end
  end

  // Clear wins, but a drop in the clearing cycle still counts as one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (drop_clr) begin
      r_drop_cnt <= w_drop ? CNT_W'(1) : '0;
    end else if (w_drop && (r_drop_cnt != C_CNT_MAX)) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign out_valid = w_nonempty;
  assign out_z     = w_nonempty ? r_mem[r_rptr] : '0;
  assign level     = r_level;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pla_b11_capture.sv
`default_nettype none
//==== tb_pla_b11_capture : directed table, corner sequences and random vs queue model ====
// Rev 1.0 - initial release
module tb_pla_b11_capture;

  localparam int DEPTH = 4;
  typedef logic [30:0] word_t;

  typedef struct {
    logic       iv;
    word_t      iz;
    logic       rdy;
    logic       clr;
    logic       ev;
    word_t      ez;
    logic [2:0] el;
    logic [7:0] ec;
  } vec_t;

  logic  clk;
  logic  rst;
  logic  iv;
  word_t iz;
  logic  rdy;
  logic  clr;

  logic       ov [3];
  word_t      oz [3];
  logic [2:0] lv [3];
  logic [7:0] dc0;
  logic [7:0] dc1;
  logic [1:0] dc2;

  int checks;
  int failures;

  // Reference model: one queue per DUT plus last-word and counter state.
  word_t mq [3][$];
  word_t mlast [3];
  bit    mlast_v [3];
  int    mcnt [3];
  int    mmax [3];
  bit    mdedup [3];

  vec_t tbl [$];

  pla_b11_capture #(.DEPTH(DEPTH), .W(31), .DEDUP(1'b1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_z(iz), .out_valid(ov[0]),
    .out_ready(rdy), .out_z(oz[0]), .level(lv[0]), .drop_cnt(dc0), .drop_clr(clr));

  pla_b11_capture #(.DEPTH(DEPTH), .W(31), .DEDUP(1'b0), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_z(iz), .out_valid(ov[1]),
    .out_ready(rdy), .out_z(oz[1]), .level(lv[1]), .drop_cnt(dc1), .drop_clr(clr));

  pla_b11_capture #(.DEPTH(DEPTH), .W(31), .DEDUP(1'b1), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_z(iz), .out_valid(ov[2]),
    .out_ready(rdy), .out_z(oz[2]), .level(lv[2]), .drop_cnt(dc2), .drop_clr(clr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] dcnt(input int k);
    case (k)
      0:       return dc0;
      1:       return dc1;
      default: return {6'b0, dc2};
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mq[k].delete();
      mlast[k]   = '0;
      mlast_v[k] = 1'b0;
      mcnt[k]    = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      int occ;
      bit pop, cand, push, drop;
      occ  = mq[k].size();
      pop  = (occ > 0) && rdy;
      cand = iv && (!mdedup[k] || !mlast_v[k] || (iz != mlast[k]));
      push = cand && ((occ < DEPTH) || pop);
      drop = cand && !push;
      if (pop) void'(mq[k].pop_front());
      if (push) begin
        mq[k].push_back(iz);
        mlast[k]   = iz;
        mlast_v[k] = 1'b1;
      end
      if (clr) mcnt[k] = drop ? 1 : 0;
      else if (drop && (mcnt[k] < mmax[k])) mcnt[k]++;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      word_t ez;
      ez = (mq[k].size() > 0) ? mq[k][0] : '0;
      check($sformatf("model_valid%0d", k), {31'b0, ov[k]}, {31'b0, mq[k].size() > 0});
      check($sformatf("model_z%0d", k), {1'b0, oz[k]}, {1'b0, ez});
      check($sformatf("model_level%0d", k), {29'b0, lv[k]}, 32'(mq[k].size()));
      check($sformatf("model_cnt%0d", k), {24'b0, dcnt(k)}, 32'(mcnt[k]));
    end
  endtask

  task automatic step(input logic v, input word_t z, input logic r, input logic c);
    iv = v; iz = z; rdy = r; clr = c;
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    rst = 1'b1; iv = 1'b0; iz = '0; rdy = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic vec_t mk(input logic v, input word_t z, input logic r, input logic c,
                              input logic ev, input word_t ez, input int el, input int ec);
    vec_t t;
    t.iv = v; t.iz = z; t.rdy = r; t.clr = c;
    t.ev = ev; t.ez = ez; t.el = 3'(el); t.ec = 8'(ec);
    return t;
  endfunction

  initial begin
    word_t ra = 31'h1234_5670;
    word_t rb = 31'h0765_4320;
    int    rmode;
    checks = 0; failures = 0;
    mmax   = '{255, 255, 3};
    mdedup = '{1'b1, 1'b0, 1'b1};

    // Single word, dedup A/A/A/B/A, fill and drop, full-with-pop wrap, clear.
    tbl.push_back(mk(1, 31'h4, 0, 0, 1, 31'h4, 1, 0));
    tbl.push_back(mk(0, 31'h0, 1, 0, 0, 31'h0, 0, 0));
    tbl.push_back(mk(1, ra, 1, 0, 1, ra, 1, 0));
    tbl.push_back(mk(1, ra, 1, 0, 0, 31'h0, 0, 0));
    tbl.push_back(mk(1, ra, 1, 0, 0, 31'h0, 0, 0));
    tbl.push_back(mk(1, rb, 1, 0, 1, rb, 1, 0));
    tbl.push_back(mk(1, ra, 1, 0, 1, ra, 1, 0));
    tbl.push_back(mk(0, 31'h0, 1, 0, 0, 31'h0, 0, 0));
    for (int j = 1; j <= 6; j++)
      tbl.push_back(mk(1, 31'(j * 'h11), 0, 0, 1, 31'h11, (j < 4) ? j : 4, (j > 4) ? j - 4 : 0));
    for (int j = 2; j <= 4; j++)
      tbl.push_back(mk(0, 31'h0, 1, 0, 1, 31'(j * 'h11), 5 - j, 2));
    tbl.push_back(mk(0, 31'h0, 1, 0, 0, 31'h0, 0, 2));
    tbl.push_back(mk(1, 31'h44, 0, 0, 0, 31'h0, 0, 2));
    for (int j = 1; j <= 4; j++)
      tbl.push_back(mk(1, 31'(32'h100 + j), 0, 0, 1, 31'h101, j, 2));
    for (int j = 5; j <= 16; j++)
      tbl.push_back(mk(1, 31'(32'h100 + j), 1, 0, 1, 31'(32'h100 + j - 3), 4, 2));
    tbl.push_back(mk(0, 31'h0, 1, 1, 1, 31'h10E, 3, 0));
    tbl.push_back(mk(0, 31'h0, 1, 0, 1, 31'h10F, 2, 0));
    tbl.push_back(mk(0, 31'h0, 1, 0, 1, 31'h110, 1, 0));
    tbl.push_back(mk(0, 31'h0, 1, 0, 0, 31'h0, 0, 0));

    apply_reset();
    check("reset_valid", {31'b0, ov[0]}, 32'd0);
    check("reset_z", {1'b0, oz[0]}, 32'd0);
    check("reset_level", {29'b0, lv[0]}, 32'd0);
    check("reset_cnt", {24'b0, dc0}, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].iv, tbl[i].iz, tbl[i].rdy, tbl[i].clr);
      check($sformatf("tbl%0d_valid", i), {31'b0, ov[0]}, {31'b0, tbl[i].ev});
      check($sformatf("tbl%0d_z", i), {1'b0, oz[0]}, {1'b0, tbl[i].ez});
      check($sformatf("tbl%0d_level", i), {29'b0, lv[0]}, {29'b0, tbl[i].el});
      check($sformatf("tbl%0d_cnt", i), {24'b0, dc0}, {24'b0, tbl[i].ec});
    end

    // Saturation, clear-with-drop, clear alone.
    apply_reset();
    for (int j = 0; j < 4; j++) step(1, 31'(32'h200 + j), 0, 0);
    for (int j = 0; j < 5; j++) step(1, 31'(32'h300 + j), 0, 0);
    check("sat_cnt8", {24'b0, dc0}, 32'd5);
    check("sat_cnt2", {30'b0, dc2}, 32'd3);
    check("sat_level", {29'b0, lv[0]}, 32'd4);
    step(1, 31'h400, 0, 1);
    check("clr_drop_cnt8", {24'b0, dc0}, 32'd1);
    check("clr_drop_cnt2", {30'b0, dc2}, 32'd1);
    step(0, 31'h0, 0, 1);
    check("clr_alone_cnt2", {30'b0, dc2}, 32'd0);
    step(1, 31'h401, 0, 0);
    step(0, 31'h0, 1, 0);
    check("pre_rst_level", {29'b0, lv[0]}, 32'd3);
    check("pre_rst_cnt", {24'b0, dc0}, 32'd1);

    // Async reset between edges must clear outputs immediately.
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("arst_valid%0d", k), {31'b0, ov[k]}, 32'd0);
      check($sformatf("arst_level%0d", k), {29'b0, lv[k]}, 32'd0);
      check($sformatf("arst_cnt%0d", k), {24'b0, dcnt(k)}, 32'd0);
    end
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 31'h203, 0, 0);
    check("post_rst_valid", {31'b0, ov[0]}, 32'd1);
    check("post_rst_z", {1'b0, oz[0]}, 32'h203);
    check("post_rst_level", {29'b0, lv[0]}, 32'd1);

    // Random traffic with a small value pool so duplicates are frequent.
    rmode = 0;
    for (int n = 0; n < 3000; n++) begin
      logic  v, r, c;
      word_t z;
      if ((n % 64) == 0) rmode = $urandom_range(0, 2);
      v = ($urandom_range(0, 9) < 7);
      z = ($urandom_range(0, 3) == 0) ? 31'($urandom) : (31'($urandom_range(0, 7)) << 1);
      case (rmode)
        0:       r = ($urandom_range(0, 9) < 2);
        1:       r = ($urandom_range(0, 9) < 5);
        default: r = ($urandom_range(0, 9) < 9);
      endcase
      c = ($urandom_range(0, 49) == 0);
      step(v, z, r, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
